mux_pipe_stage: RTL and testbench
=================================

Name: mux_pipe_stage

Overview:
- Parametrised N-input, WIDTH-bit selector with a registered output and a valid/ready handshake.
- Replaces the single-bit 4:1 selector in the pipeline's operand paths: ALU source select, forwarding select, writeback select.
- Absorbs back-pressure through a 2-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`.
- Pipeline flush support drops in-flight selections.

Parameters:
- `WIDTH`, 32, bit width of each data input and of the output.
- `N_IN`, 4, number of data inputs; legal range 2..16.
- `SEL_W`, `$clog2(N_IN)`, width of the select field. Derived; not overridden.
- `DEFAULT_VAL`, 0, output data when select ≥ `N_IN`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all buffered entries (pipeline flush).
- `in_data`  in  `WIDTH*N_IN`  packed inputs; input k occupies `[k*WIDTH +: WIDTH]`.
- `select`  in  `SEL_W`  input index, sampled together with `in_data`.
- `in_valid`  in  1  `in_data`/`select` valid this cycle.
- `in_ready`  out  1  stage can accept an entry this cycle.
- `out_data`  out  `WIDTH`  selected word.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.

Behaviour:
- Reset: `out_valid`=0, `out_data`=0, skid entry invalid and its data 0.
- `in_ready`=0 while `rst`=1.
- Input transfer: `in_valid` & `in_ready` on a clock edge.
- Output transfer: `out_valid` & `out_ready` on a clock edge.
- Selection is combinational on the input side:
  - `sel_word` = input[`select`] when `select` < `N_IN`, else `DEFAULT_VAL`.
  - Only `sel_word` is stored; raw inputs are never stored.
- Latency: 1 cycle from input transfer to `out_valid`, when the output register is empty or draining.
- `in_ready` = ~`skid_valid` & ~`rst`. It is a registered-state function only, with no combinational path from `out_ready`.
- States, encoded by (`out_valid`, `skid_valid`):
  - EMPTY (0,0):
    - input transfer → FULL1, with `out_data` ← `sel_word`.
  - FULL1 (1,0):
    - input transfer and output transfer → FULL1, `out_data` ← `sel_word`.
    - input transfer, no output transfer → FULL2, skid ← `sel_word`.
    - output transfer only → EMPTY.
    - neither → hold.
  - FULL2 (1,1): `in_ready`=0.
    - output transfer → FULL1, `out_data` ← skid, skid invalidated.
    - otherwise hold.
- Order is preserved: `out_data` always presents the oldest entry.
- `out_data` holds its value while `out_valid`=1 and `out_ready`=0. It is never altered under a stall.
- Flush:
  - On a flush edge, `out_valid` and `skid_valid` ← 0, and any simultaneous input transfer is discarded.
  - `out_data` keeps its stale value, so downstream must qualify it with `out_valid`.
  - Flush overrides all other events except `rst`.
- `rst` overrides `flush` and the handshake. Reset mid-operation drops all entries within one edge.
- `out_valid` after a drain: `out_valid` returns to 0 on the edge where the last entry transfers with no new input.
- `out_data` after a drain: `out_data` keeps its last value.
- `N_IN` not a power of two: select codes `N_IN`..2^`SEL_W`-1 yield `DEFAULT_VAL`. They are a legal transfer, not an error, unless the optional feature is enabled.

Optional Feature:
- Macro: `MUX_PIPE_SEL_ERR_EN`.
- Defined:
  - Adds output port `sel_err` (1 bit), reset 0.
  - `sel_err` is set on the edge of any input transfer with `select` ≥ `N_IN`, and is sticky until `rst`.
  - Flush does not clear it.
  - Data behaviour is unchanged; `DEFAULT_VAL` is still passed.
- Undefined: no `sel_err` port, no error-tracking logic.

Test Plan:
- Reset and pass-through:
  - Stimulus: `rst` held 2 cycles, then `N_IN`=4, `WIDTH`=32, inputs 0x11,0x22,0x33,0x44, `select`=2, `in_valid`=1, `out_ready`=1.
  - Response: `out_valid`=1 one cycle after the transfer, with `out_data`=0x33.
  - During reset: `out_valid`=0, `out_data`=0, `in_ready`=0.
- Back-pressure:
  - Stimulus: `out_ready`=0, three back-to-back valid inputs with `select`=0,1,3.
  - Response: the first two are accepted and `in_ready` drops after the second. Then `out_ready`=1 delivers 0x11 then 0x22 in order, and `in_ready` re-asserts after the first drain.
- Streaming:
  - Stimulus: `out_ready`=1, `in_valid`=1 for 8 cycles, `select` cycling 0..3.
  - Response: 8 outputs, 1-cycle latency, `in_ready` stays 1, no bubbles.
- Flush in FULL2:
  - Stimulus: fill both entries, then pulse `flush` together with `in_valid`=1.
  - Response: next cycle `out_valid`=0 and `in_ready`=1; the flushed-cycle input never appears at the output.
- Out-of-range select:
  - Stimulus: `N_IN`=3, `DEFAULT_VAL`=0xDEAD, `select`=3.
  - Response: `out_data`=0xDEAD.
  - With `MUX_PIPE_SEL_ERR_EN` defined: `sel_err`=1 from the next cycle, and it stays 1 through a `flush` until `rst`.
- Reset mid-stream:
  - Stimulus: FULL2 with `out_ready`=0, assert `rst` for 1 cycle.
  - Response: `out_valid`=0 and `out_data`=0 on that edge; no stale entries emerge afterwards.

Source files
------------

// File: rtl/mux_pipe_stage.sv
// ---------------------------------------------------------------------------
// mux_pipe_stage
//
// N_IN-input, WIDTH-bit selector with a registered output and a valid/ready
// handshake. The selected word is stored; the raw inputs are not. A
// two-entry skid arrangement (output register plus one skid register) absorbs
// back-pressure, so in_ready is a function of registered state and rst only.
// It never depends combinationally on out_ready.
//
// Parameters
//   WIDTH       bit width of each data input and of the output
//   N_IN        number of data inputs (2..16)
//   SEL_W       select width, derived as $clog2(N_IN); do not override
//   DEFAULT_VAL word produced when select >= N_IN
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   flush      in   drop every buffered entry and any same-edge input
//   in_data    in   packed inputs, input k at [k*WIDTH +: WIDTH]
//   select     in   input index, sampled together with in_data
//   in_valid   in   in_data/select valid
//   in_ready   out  stage can accept an entry this cycle
//   out_data   out  oldest buffered selected word
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts out_data this cycle
//   sel_err    out  (only with MUX_PIPE_SEL_ERR_EN) sticky flag: an input
//                   transfer used select >= N_IN; cleared only by rst
//
// Optional feature macro: MUX_PIPE_SEL_ERR_EN
// ---------------------------------------------------------------------------
module mux_pipe_stage #(
  parameter int                 WIDTH       = 32,
  parameter int                 N_IN        = 4,
  parameter int                 SEL_W       = $clog2(N_IN),
  parameter logic [WIDTH-1:0]   DEFAULT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [WIDTH*N_IN-1:0] in_data,
  input  logic [SEL_W-1:0]      select,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef MUX_PIPE_SEL_ERR_EN
  ,
  output logic                  sel_err
`endif
);

  // State encodes (out_valid, skid_valid) directly.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL1 = 2'b10,
    FULL2 = 2'b11
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  out_data_q;
  logic [WIDTH-1:0]  out_data_d;
  logic [WIDTH-1:0]  skid_data_q;
  logic [WIDTH-1:0]  skid_data_d;

  logic [WIDTH-1:0]  sel_word;
  logic              skid_valid;
  logic              in_xfer;
  logic              out_xfer;

  // -------------------------------------------------------------------------
  // Input side: combinational selection
  // -------------------------------------------------------------------------
  // Unused select codes (N_IN not a power of two) fall through to
  // DEFAULT_VAL; they are a legal transfer.
  always_comb begin
    sel_word = DEFAULT_VAL;
    for (int k = 0; k < N_IN; k++) begin
      if (select == SEL_W'(k)) begin
        sel_word = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign out_valid  = (state_q == FULL1) || (state_q == FULL2);
  assign skid_valid = (state_q == FULL2);

  // Only registered state and rst feed in_ready, which keeps out_ready off
  // the upstream ready path.
  assign in_ready = ~skid_valid & ~rst;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // -------------------------------------------------------------------------
  // Next-state: output register + skid entry
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // out_data keeps its stale value; consumers must qualify with out_valid.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d    = FULL1;
            out_data_d = sel_word;
          end
        end

        FULL1: begin
          if (in_xfer && out_xfer) begin
            out_data_d = sel_word;
          end else if (in_xfer) begin
            // Output stalled: park the new word behind it.
            state_d     = FULL2;
            skid_data_d = sel_word;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end

        FULL2: begin
          // in_ready is low here, so only the drain can happen.
          if (out_xfer) begin
            state_d    = FULL1;
            out_data_d = skid_data_q;
          end
        end

        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_data = out_data_q;

`ifdef MUX_PIPE_SEL_ERR_EN
  // -------------------------------------------------------------------------
  // Sticky out-of-range select flag
  // -------------------------------------------------------------------------
  logic sel_oob;
  logic sel_err_q;
  logic sel_err_d;

  assign sel_oob = (int'(select) >= N_IN);

  // The handshake completed even if flush then discards the entry, so the
  // flag still records it; flush itself never clears the flag.
  always_comb begin
    sel_err_d = sel_err_q;
    if (in_xfer && sel_oob) begin
      sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_pipe_stage.sv
module tb_mux_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;

  // Main instance: WIDTH=32, N_IN=4, DEFAULT_VAL=0
  logic [127:0] in_data;
  logic [1:0]   select;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;

  // Second instance: WIDTH=16, N_IN=3, DEFAULT_VAL=0xDEAD
  logic [47:0]  in_data2;
  logic [1:0]   select2;
  logic         in_valid2;
  logic         in_ready2;
  logic [15:0]  out_data2;
  logic         out_valid2;
  logic         out_ready2;

`ifdef MUX_PIPE_SEL_ERR_EN
  logic         sel_err;
  logic         sel_err2;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_pipe_stage #(
    .WIDTH(32), .N_IN(4), .DEFAULT_VAL(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .select(select), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MUX_PIPE_SEL_ERR_EN
    , .sel_err(sel_err)
`endif
  );

  mux_pipe_stage #(
    .WIDTH(16), .N_IN(3), .DEFAULT_VAL(16'hDEAD)
  ) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data2), .select(select2), .in_valid(in_valid2),
    .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready2)
`ifdef MUX_PIPE_SEL_ERR_EN
    , .sel_err(sel_err2)
`endif
  );

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    in_data = {32'h44, 32'h33, 32'h22, 32'h11};
    select = 2'd1; in_valid = 1'b1; out_ready = 1'b0;
    in_data2 = {16'h000C, 16'h000B, 16'h000A};
    select2 = 2'd0; in_valid2 = 1'b0; out_ready2 = 1'b1;
    step(); step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_vec++; if (out_data2 !== 16'h0) begin n_err++; $display("FAIL reset_out_data2: got %h want 0", out_data2); end
`ifdef MUX_PIPE_SEL_ERR_EN
    n_vec++; if (sel_err2 !== 1'b0) begin n_err++; $display("FAIL reset_sel_err2: got %b want 0", sel_err2); end
`endif
    in_valid = 1'b0;
  endtask

  task automatic test_pass_through();
    rst = 1'b0; select = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pt_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pt_out_valid: got %b want 1", out_valid); end
    n_vec++; if (out_data !== 32'h33) begin n_err++; $display("FAIL pt_out_data: got %h want 00000033", out_data); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pt_drain_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 32'h33) begin n_err++; $display("FAIL pt_drain_data_hold: got %h want 00000033", out_data); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0; in_valid = 1'b1; select = 2'd0;
    step();                                    // accepted -> out=0x11
    select = 2'd1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_first: got %b want 1", in_ready); end
    step();                                    // accepted -> skid=0x22
    select = 2'd3;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_after_second: got %b want 0", in_ready); end
    step();                                    // third not accepted
    n_vec++; if (out_data !== 32'h11) begin n_err++; $display("FAIL bp_stall_data: got %h want 00000011", out_data); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_stall_valid: got %b want 1", out_valid); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_vec++; if (out_data !== 32'h22) begin n_err++; $display("FAIL bp_second_data: got %h want 00000022", out_data); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_reassert: got %b want 1", in_ready); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 32'h22) begin n_err++; $display("FAIL bp_no_third: got %h want 00000022", out_data); end
  endtask

  task automatic test_streaming();
    logic [31:0] words [4];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      select = 2'(i % 4);
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL st_in_ready[%0d]: got %b want 1", i, in_ready); end
      step();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL st_out_valid[%0d]: got %b want 1", i, out_valid); end
      n_vec++; if (out_data !== words[i % 4]) begin n_err++; $display("FAIL st_out_data[%0d]: got %h want %h", i, out_data, words[i % 4]); end
    end
    in_valid = 1'b0;
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL st_end_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; select = 2'd0;
    step(); select = 2'd1;
    step();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_full2_ready: got %b want 0", in_ready); end
    flush = 1'b1; select = 2'd3;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_out_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fl_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_no_stale[%0d]: got %b want 0", i, out_valid); end
    end
    // Flush from EMPTY with an accepted input: the input is dropped.
    flush = 1'b1; in_valid = 1'b1; select = 2'd3;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_drop_input: got %b want 0", out_valid); end
  endtask

  task automatic test_out_of_range();
    select2 = 2'd3; in_valid2 = 1'b1; out_ready2 = 1'b0;
`ifdef MUX_PIPE_SEL_ERR_EN
    #1;
    n_vec++; if (sel_err2 !== 1'b0) begin n_err++; $display("FAIL oor_err_before: got %b want 0", sel_err2); end
`endif
    step();
    in_valid2 = 1'b0;
    n_vec++; if (out_valid2 !== 1'b1) begin n_err++; $display("FAIL oor_valid: got %b want 1", out_valid2); end
    n_vec++; if (out_data2 !== 16'hDEAD) begin n_err++; $display("FAIL oor_data: got %h want dead", out_data2); end
`ifdef MUX_PIPE_SEL_ERR_EN
    n_vec++; if (sel_err2 !== 1'b1) begin n_err++; $display("FAIL oor_err_set: got %b want 1", sel_err2); end
    n_vec++; if (sel_err !== 1'b0) begin n_err++; $display("FAIL oor_err_main: got %b want 0", sel_err); end
`endif
    out_ready2 = 1'b1; select2 = 2'd1; in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    n_vec++; if (out_data2 !== 16'h000B) begin n_err++; $display("FAIL oor_inrange_data: got %h want 000b", out_data2); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_vec++; if (out_valid2 !== 1'b0) begin n_err++; $display("FAIL oor_flush_valid: got %b want 0", out_valid2); end
`ifdef MUX_PIPE_SEL_ERR_EN
    n_vec++; if (sel_err2 !== 1'b1) begin n_err++; $display("FAIL oor_err_after_flush: got %b want 1", sel_err2); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if (sel_err2 !== 1'b0) begin n_err++; $display("FAIL oor_err_after_rst: got %b want 0", sel_err2); end
`endif
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b0; in_valid = 1'b1; select = 2'd2;
    step(); select = 2'd3;
    step();
    in_valid = 1'b0;
    n_vec++; if (out_data !== 32'h33) begin n_err++; $display("FAIL rm_full2_data: got %h want 00000033", out_data); end
    rst = 1'b1;
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rm_out_data: got %h want 0", out_data); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rm_in_ready: got %b want 0", in_ready); end
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_no_stale[%0d]: got %b want 0", i, out_valid); end
    end
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rm_data_after: got %h want 0", out_data); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_back_pressure();
    test_streaming();
    test_flush();
    test_out_of_range();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
